eqed_inject_misr_ctrl: RTL
==========================

# eqed_inject_misr_ctrl

Parametrised E-QED harness controller. It generates a one-hot, single-cycle bit-flip select for `NUM_FF` E-QED muxes inside a design module, and compresses the module's inputs and outputs into two MISRs over a fixed capture window. It then reports whether both final signatures match their expected values. It sits in the top-level E-QED wrapper between the formal/bench stimulus and the design module's `eqed_sel` wires, and generalises the fixed 8-FF / 6-bit / 5-cycle setup to arbitrary sizes with a run FSM and scheduled injection.

## Interface
Parameters:
- `NUM_FF`, 8: number of injectable FFs, width of `eqed_sel`.
- `SEL_W`, `$clog2(NUM_FF+1)`: width of `inj_sel`.
- `IN_W`, 2: design-module input bits compressed.
- `OUT_W`, 3: design-module output bits compressed.
- `MISR_W`, 6: MISR width; requires `2*IN_W <= MISR_W` and `2*OUT_W <= MISR_W`.
- `MISR_TAPS`, 6'b110000: feedback tap mask.
- `WINDOW`, 5: capture window length in cycles, at least 1.
- `CNT_W`, 10: width of cycle and window counters.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: start-run pulse.
- `mode`, in, 1: 0 = on-request injection, 1 = scheduled injection.
- `inj_req`, in, 1: mode-0 injection request.
- `inj_sel`, in, `SEL_W`: binary FF index; any value `>= NUM_FF` means no injection.
- `inj_cycle`, in, `CNT_W`: mode-1 window cycle at which to inject.
- `dut_in`, in, `IN_W`: design-module inputs.
- `dut_out`, in, `OUT_W`: design-module outputs.
- `exp_in_sig`, in, `MISR_W`: expected final input signature.
- `exp_out_sig`, in, `MISR_W`: expected final output signature.
- `eqed_sel`, out, `NUM_FF`: one-hot flip select, combinational.
- `error_injected`, out, 1: sticky flag, set once an injection has occurred.
- `busy`, out, 1: FSM is in RUN.
- `done`, out, 1: FSM is in DONE.
- `match`, out, 1: both signatures equal their expected values; valid when `done`.
- `in_sig`, out, `MISR_W`: input MISR state.
- `out_sig`, out, `MISR_W`: output MISR state.
- `cycle_count`, out, `CNT_W`: free-running cycle counter.
- `win_count`, out, `CNT_W`: cycles elapsed in the current run.

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE: `start` → RUN.
  - RUN: after `WINDOW` RUN cycles → DONE.
  - DONE: `start` → RUN, which is a restart.
  - `start` is ignored while in RUN.
- Entering RUN, on the `start` cycle edge:
  - `in_sig` and `out_sig` load seed 1 (bit0 = 1).
  - `win_count` loads 0.
  - `error_injected` clears.
- MISR update, on every RUN cycle:
  - `sig_next[0] = ^(sig & MISR_TAPS) ^ d[0]`.
  - `sig_next[k] = sig[k-1] ^ (k even && k/2 < W ? d[k/2] : 0)`.
  - Data bit j therefore enters MISR bit 2j. `d` is `dut_in` for `in_sig` and `dut_out` for `out_sig`.
- MISRs hold their value in IDLE and DONE.
- Injection is allowed only in RUN, with `error_injected` = 0 and `inj_sel < NUM_FF`. The injection condition is:
  - mode 0: `inj_req` = 1;
  - mode 1: `win_count == inj_cycle`.
- When the condition holds, `eqed_sel` = `1 << inj_sel`. Otherwise `eqed_sel` = 0. It is never multi-hot.
- At most one injection per run. `error_injected` sets on the edge that ends the injecting cycle.
- In mode 1, an `inj_cycle >= WINDOW` produces no injection.
- `match` = (`in_sig == exp_in_sig`) && (`out_sig == exp_out_sig`), registered on entry to DONE and held until the next `start` or `rst`.
- `cycle_count` loads 1 at reset, then increments every cycle in every state and wraps modulo 2^`CNT_W`.

## Timing
- Reset values:
  - state IDLE;
  - `in_sig` = `out_sig` = 1;
  - `win_count` = 0;
  - `cycle_count` = 1;
  - `error_injected`, `busy`, `done`, `match` = 0;
  - `eqed_sel` = 0.
- `rst` in any state, including mid-run, returns to the reset values on the next edge and discards the run. `rst` has priority over `start`.
- `busy` rises 1 cycle after `start`. `done` rises exactly `WINDOW` cycles after `busy` rises, so `start` to `done` is `WINDOW+1` cycles.
- Injection has zero latency. `eqed_sel` is combinational in the cycle where the condition holds, so the flipped value is captured by the target FF at that cycle's edge.
- `inj_req` held high across several RUN cycles injects only in the first cycle.
- `start` asserted in the same cycle DONE is entered is ignored; it must arrive in DONE.

## Test plan
- Zero data, defaults: pulse `start`, hold `dut_in` = `dut_out` = 0 for 5 cycles → `done` = 1 at `start`+6, `in_sig` = `out_sig` = 6'h21, and `match` = 1 when both expected values are 6'h21.
- Mode 1, `inj_sel` = 5, `inj_cycle` = 2 → `eqed_sel` = 8'h20 only in the RUN cycle with `win_count` = 2, `error_injected` = 1 on the next cycle, and no further pulses.
- Mode 0, `inj_req` held high for 3 RUN cycles with `inj_sel` = 0 → a single cycle of `eqed_sel` = 8'h01.
- `inj_sel` = 8, or `inj_cycle` = 7 → `eqed_sel` stays 0 and `error_injected` stays 0 for the whole run.
- `rst` at `win_count` = 3 → next cycle: IDLE, signatures = 1, `cycle_count` = 1. `start` during RUN → ignored, and `done` still arrives on schedule.
- Mismatch: expected `in_sig` = 6'h21 but `dut_in[0]` = 1 in one cycle → `match` = 0 in DONE. `start` from DONE → `done` and `match` clear and a new run begins.

Source files
------------

// File: rtl/eqed_inject_misr_ctrl.sv
// E-QED harness controller: one-hot single-cycle bit-flip select for the
// design module's E-QED muxes, plus input/output MISR compression over a
// fixed capture window and a final signature compare.
module eqed_inject_misr_ctrl #(
    parameter int                NUM_FF    = 8,
    parameter int                SEL_W     = $clog2(NUM_FF + 1),
    parameter int                IN_W      = 2,
    parameter int                OUT_W     = 3,
    parameter int                MISR_W    = 6,
    parameter logic [MISR_W-1:0] MISR_TAPS = 6'b110000,
    parameter int                WINDOW    = 5,
    parameter int                CNT_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              inj_req,
    input  logic [SEL_W-1:0]  inj_sel,
    input  logic [CNT_W-1:0]  inj_cycle,
    input  logic [IN_W-1:0]   dut_in,
    input  logic [OUT_W-1:0]  dut_out,
    input  logic [MISR_W-1:0] exp_in_sig,
    input  logic [MISR_W-1:0] exp_out_sig,
    output logic [NUM_FF-1:0] eqed_sel,
    output logic              error_injected,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic [MISR_W-1:0] in_sig,
    output logic [MISR_W-1:0] out_sig,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  win_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [MISR_W-1:0] SEED     = MISR_W'(1);
    localparam logic [CNT_W-1:0]  LAST_WIN = CNT_W'(WINDOW - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [MISR_W-1:0] r_in_sig;
    logic [MISR_W-1:0] r_out_sig;
    logic [MISR_W-1:0] w_in_sig_next;
    logic [MISR_W-1:0] w_out_sig_next;
    logic [CNT_W-1:0]  r_win_count;
    logic [CNT_W-1:0]  r_cycle_count;
    logic              r_error_injected;
    logic              r_match;
    logic              w_run;
    logic              w_last;
    logic              w_start_run;
    logic              w_inject;

    assign w_run       = (r_state == ST_RUN);
    assign w_last      = w_run && (r_win_count == LAST_WIN);
    // start only counts outside RUN; IDLE starts a run, DONE restarts one
    assign w_start_run = start && !w_run;

    // One injection per run, only for a valid FF index; mode picks the trigger
    assign w_inject = w_run && !r_error_injected &&
                      (inj_sel < SEL_W'(NUM_FF)) &&
                      (mode ? (r_win_count == inj_cycle) : inj_req);

    // Decode the FF index; at most one bit can match so the select is one-hot
    for (genvar gi = 0; gi < NUM_FF; gi++) begin : g_sel
        assign eqed_sel[gi] = w_inject && (inj_sel == SEL_W'(gi));
    end

    // MISR feedback into bit 0 together with data bit 0
    assign w_in_sig_next[0]  = (^(r_in_sig & MISR_TAPS)) ^ dut_in[0];
    assign w_out_sig_next[0] = (^(r_out_sig & MISR_TAPS)) ^ dut_out[0];

    // Shift stages; data bit j is folded in at MISR bit 2j
    for (genvar gi = 1; gi < MISR_W; gi++) begin : g_misr
        if ((gi % 2 == 0) && (gi / 2 < IN_W)) begin : g_in_d
            assign w_in_sig_next[gi] = r_in_sig[gi-1] ^ dut_in[gi/2];
        end else begin : g_in_s
            assign w_in_sig_next[gi] = r_in_sig[gi-1];
        end
        if ((gi % 2 == 0) && (gi / 2 < OUT_W)) begin : g_out_d
            assign w_out_sig_next[gi] = r_out_sig[gi-1] ^ dut_out[gi/2];
        end else begin : g_out_s
            assign w_out_sig_next[gi] = r_out_sig[gi-1];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next-state: IDLE/DONE wait for start, RUN lasts WINDOW cycles
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: if (start)  w_state_next = ST_RUN;
            default:             w_state_next = ST_IDLE;
        endcase
    end

    // Run datapath: seed on start, compress during RUN, latch verdict at the end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_sig         <= SEED;
            r_out_sig        <= SEED;
            r_win_count      <= '0;
            r_error_injected <= 1'b0;
            r_match          <= 1'b0;
        end else if (w_start_run) begin
            r_in_sig         <= SEED;
            r_out_sig        <= SEED;
            r_win_count      <= '0;
            r_error_injected <= 1'b0;
            r_match          <= 1'b0;
        end else if (w_run) begin
            r_in_sig    <= w_in_sig_next;
            r_out_sig   <= w_out_sig_next;
            r_win_count <= r_win_count + CNT_W'(1);
            if (w_inject) r_error_injected <= 1'b1;
            // compare the signatures that are being written on this final edge
            if (w_last) begin
                r_match <= (w_in_sig_next == exp_in_sig) &&
                           (w_out_sig_next == exp_out_sig);
            end
        end
    end

    // Free-running cycle counter, 1 after reset, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) r_cycle_count <= CNT_W'(1);
        else     r_cycle_count <= r_cycle_count + CNT_W'(1);
    end

    assign error_injected = r_error_injected;
    assign busy           = w_run;
    assign done           = (r_state == ST_DONE);
    assign match          = r_match;
    assign in_sig         = r_in_sig;
    assign out_sig        = r_out_sig;
    assign cycle_count    = r_cycle_count;
    assign win_count      = r_win_count;

endmodule
